// File: rtl/user_input_debounce_pkg.sv
// Shared constants and control-FSM encoding for the user input conditioning path.
package user_io_pkg;

    localparam int CLK_50M_HZ    = 50_000_000;
    localparam int DEBOUNCE_10MS = 500000;

    // INIT loads the first synchronized levels, RUN debounces until the next reset.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/user_input_debounce_if.sv
// Bundle of raw pins and conditioned outputs between the board pins and the LED stage.
interface user_input_debounce_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] USER_IN_RAW;
    logic [WIDTH-1:0] USER_IN_LEVEL;
    logic [WIDTH-1:0] USER_IN_RISE;
    logic [WIDTH-1:0] USER_IN_FALL;
    logic             USER_IN_VALID;

    // Board side: drives the pins and consumes the conditioned levels and pulses.
    modport master (
        output USER_IN_RAW,
        input  USER_IN_LEVEL,
        input  USER_IN_RISE,
        input  USER_IN_FALL,
        input  USER_IN_VALID
    );

    // Conditioner side.
    modport slave (
        input  USER_IN_RAW,
        output USER_IN_LEVEL,
        output USER_IN_RISE,
        output USER_IN_FALL,
        output USER_IN_VALID
    );

endinterface

// File: rtl/user_input_debounce_debounce_bit.sv
// Single-bit conditioner: two-flop synchronizer, optional inversion, hold counter,
// registered level and registered one-cycle rise/fall pulses.
module debounce_bit
    import user_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic raw,
    input  logic en,
    input  logic load,
    output logic level,
    output logic rise,
    output logic fall
);

    // A one-cycle debounce still needs a 1-bit counter to keep the vector legal.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_reg;
    logic             s2_reg;
    logic             sync;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             level_reg;
    logic             level_next;
    logic             rise_reg;
    logic             rise_next;
    logic             fall_reg;
    logic             fall_next;

    // Two-stage synchronizer for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (srst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= raw;
            s2_reg <= s1_reg;
        end
    end

    assign sync = s2_reg ^ INVERT;

    // Load on INIT exit, otherwise count consecutive mismatches and commit at the last one.
    always_comb begin
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (load) begin
            level_next = sync;
            cnt_next   = '0;
        end else if (en) begin
            if (sync == level_reg) begin
                cnt_next = '0;
            end else if (cnt_reg != CNT_LAST) begin
                cnt_next = cnt_reg + 1'b1;
            end else begin
                level_next = sync;
                cnt_next   = '0;
                rise_next  = sync;
                fall_next  = ~sync;
            end
        end else begin
            cnt_next = '0;
        end
    end

    // Counter, level and pulse registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/user_input_debounce.sv
// Debounces the board DIP switches / push buttons and produces edge pulses.
// The top holds only the INIT/RUN control FSM, its init counter and the valid flag.
module user_input_debounce
    import user_io_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter logic [WIDTH-1:0] INVERT_MASK     = '0
) (
    input  logic                CLK_50M_FPGA,
    input  logic                GLOBAL_RESET,
    user_input_debounce_if.slave user_io
);

    // Synchronizer needs two edges to fill, so the initial load happens on the third.
    localparam logic [1:0] INIT_LAST = 2'd2;

    ctrl_state_t      state_reg;
    ctrl_state_t      state_next;
    logic [1:0]       init_cnt_reg;
    logic [1:0]       init_cnt_next;
    logic             valid_reg;
    logic             load_strobe;
    logic             run_en;
    logic [WIDTH-1:0] level_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;

    // FSM state and init counter registers.
    always_ff @(posedge CLK_50M_FPGA) begin
        if (GLOBAL_RESET) begin
            state_reg    <= INIT;
            init_cnt_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    // Next state: count through INIT, then stay in RUN until reset.
    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            INIT: begin
                init_cnt_next = init_cnt_reg + 1'b1;
                if (init_cnt_reg == INIT_LAST) begin
                    state_next = RUN;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // FSM outputs: one-cycle load strobe on INIT exit, debounce enable while running.
    always_comb begin
        load_strobe = (state_reg == INIT) && (init_cnt_reg == INIT_LAST);
        run_en      = (state_reg == RUN);
    end

    // Valid goes high with the initial level load and stays high until reset.
    always_ff @(posedge CLK_50M_FPGA) begin
        if (GLOBAL_RESET) begin
            valid_reg <= 1'b0;
        end else if (load_strobe) begin
            valid_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INVERT          (INVERT_MASK[gi])
            ) u_bit (
                .clk   (CLK_50M_FPGA),
                .srst  (GLOBAL_RESET),
                .raw   (user_io.USER_IN_RAW[gi]),
                .en    (run_en),
                .load  (load_strobe),
                .level (level_vec[gi]),
                .rise  (rise_vec[gi]),
                .fall  (fall_vec[gi])
            );
        end
    endgenerate

    assign user_io.USER_IN_LEVEL = level_vec;
    assign user_io.USER_IN_RISE  = rise_vec;
    assign user_io.USER_IN_FALL  = fall_vec;
    assign user_io.USER_IN_VALID = valid_reg;

endmodule
